aes_spi_master: RTL and testbench
=================================

# aes_spi_master

Serial initiator for the AES SPI link. Latches a 128-bit message, a left-aligned key and a key-size code from the system side, then serialises them to the AES slave over SIMO under chip-select CSS. It optionally switches the link to decrypt mode and captures the 128-bit result returned on SOMI. The block sits on the host side of the link and shares `clk` with the slave: master launches on a rising edge, slave samples on the next.

## Interface
- `PAD_BITS`, 1: dummy bits sent before the message.
- `GAP_CYCLES`, 1: CSS-low idle cycles between message and key, SIMO=0.
- `clk` in 1: single system clock, shared with the slave.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `size_in` in 2: key-size code; 00=128, 01=192, 10=256, 11=illegal.
- `msg_in` in 128: plaintext, sent LSB first.
- `key_in` in 256: key, left-aligned; the N-bit key occupies bits [255:256-N].
- `SOMI` in 1: serial data from the slave.
- `SIMO` out 1: serial data to the slave.
- `CSS` out 1: chip select, active-low.
- `mode` out 1: 0=load/encrypt, 1=decrypt readback.
- `size` out 2: latched size code, held stable for the whole transaction.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse when start is rejected for size 11.
- `result` out 128: captured readback word; holds until the next capture.

## Operation
- Reset values, applied asynchronously: CSS=1, SIMO=0, mode=0, size=00, busy=0, done=0, err=0, result=0, state IDLE.
- States: IDLE, PAD, MSG, GAP, KEY, TURN, READ, CAPT. The last three exist only with readback compiled in.
- IDLE:
  - start=1 with size_in≠11: latch msg_in, key_in and size_in. Go to PAD with CSS=0, mode=0, busy=1.
  - start=1 with size_in=11: pulse err for one cycle and stay in IDLE. CSS stays 1.
- PAD: send PAD_BITS zeros.
- MSG: send msg_in[0] through msg_in[127], one bit per cycle.
- GAP: hold CSS=0 and SIMO=0 for GAP_CYCLES.
- KEY: send key_in[256-N] through key_in[255], ascending. N is 128, 192 or 256.
- CSS stays low continuously from PAD through the end of KEY, for L = PAD_BITS+128+GAP_CYCLES+N cycles.
- TURN: one cycle with CSS=1, mode=1, SIMO=0.
- READ: CSS=0 for exactly 128 cycles, mode=1.
  - SOMI bit k is sampled on the (k+2)-th rising edge after CSS falls.
  - The sampled bit is written to result[k], LSB first.
- CAPT: one cycle after CSS rises. The final bit (k=127) is captured here, done pulses, busy drops, and the state returns to IDLE.
- In every state except IDLE, start is ignored.
- mode and size change only in IDLE or at the TURN entry.

## Timing
- All outputs are registered. The start-accept edge is s0; CSS falls at s0.
- With readback:
  - CSS rises at s0+L, falls at s0+L+1, rises again at s0+L+129.
  - result is complete and done=1 at s0+L+130.
  - busy is high from s0 through s0+L+129.
- Without readback: CSS rises, done pulses and busy drops together at s0+L.
- N=128, defaults: L=258, done at s0+388. N=192: L=322, done at s0+452.
- Reset mid-transaction: outputs go to their reset values immediately. The partial result is discarded (result=0), and no done or err is pulsed.
- start and reset release in the same cycle: start is ignored.

## Configuration
- `AES_SPI_READBACK_EN`
  - Defined: TURN, READ and CAPT are compiled in, and result is captured as above.
  - Undefined: the transaction ends after KEY. result is tied to 0, mode stays 0, and SOMI is unused.

## Test plan
- Reset: hold reset=0, then release → CSS=1, SIMO=0, busy=0, done=0, result=0.
- Load, size 00:
  - Stimulus: msg_in=128'h0123456789ABCDEF_FEDCBA9876543210, key_in[255:128]=128'h000102…0F, start pulse.
  - Response: CSS low for 258 cycles. SIMO order is 1 pad zero, msg LSB first, 1 gap zero, then key_in[128..255].
  - A slave-side shift model reproduces msg and key exactly.
- Size 01: 192-bit key → CSS low for 322 cycles; last key bit sent is key_in[255]; done at s0+452.
- Readback (`AES_SPI_READBACK_EN` defined):
  - Stimulus: slave model returns 128'hDEADBEEF_00112233_44556677_8899AABB with 1-cycle SOMI latency.
  - Response: result equals that value and done pulses at s0+L+130.
- Illegal size: start with size_in=11 → err=1 for one cycle, CSS stays 1, busy=0.
- Reset mid-MSG: reset=0 at cycle 60 → CSS=1 the same cycle. A fresh start after release produces a complete, correct frame.

Source files
------------

// File: rtl/aes_spi_master.sv
// Serial initiator for the AES SPI link: frames pad, message, gap and key on SIMO under CSS,
// optionally followed by a 128-bit readback on SOMI (compile with AES_SPI_READBACK_EN).
module aes_spi_master #(
    parameter int PAD_BITS   = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   size_in,
    input  logic [127:0] msg_in,
    input  logic [255:0] key_in,
    input  logic         SOMI,
    output logic         SIMO,
    output logic         CSS,
    output logic         mode,
    output logic [1:0]   size,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] result,
    output logic [2:0]   state_dbg
);

    // PAD_BITS and GAP_CYCLES are expected to lie in 1..256.
    typedef enum logic [2:0] {
        IDLE,
        PAD,
        MSG,
        GAP,
        KEY
`ifdef AES_SPI_READBACK_EN
        , TURN,
        READ,
        CAPT
`endif
    } state_t;

    localparam logic [7:0] PAD_LAST = 8'(PAD_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [127:0]   msg_q;
    logic [255:0]   key_q;
    logic [7:0]     key_last;
    logic           simo_d, css_d, mode_d, busy_d, done_d, err_d;
    logic           latch;
    logic           shift_en, capture;

    assign state_dbg = state_q;

    always_comb begin
        case (size)
            2'b00:   key_last = 8'd127;
            2'b01:   key_last = 8'd191;
            default: key_last = 8'd255;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        simo_d   = 1'b0;
        css_d    = CSS;
        mode_d   = mode;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        latch    = 1'b0;
        shift_en = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_in == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_d = PAD;
                        cnt_d   = 8'd0;
                        css_d   = 1'b0;
                        mode_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            // Each state describes the bit currently on SIMO; the comb logic picks the next one.
            PAD: begin
                if (cnt_q == PAD_LAST) begin
                    state_d = MSG;
                    cnt_d   = 8'd0;
                    simo_d  = msg_q[0];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MSG: begin
                if (cnt_q == 8'd127) begin
                    state_d = GAP;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    simo_d = msg_q[cnt_q[6:0] + 7'd1];
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = KEY;
                    cnt_d   = 8'd0;
                    simo_d  = key_q[0];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            KEY: begin
                if (cnt_q == key_last) begin
                    cnt_d = 8'd0;
                    css_d = 1'b1;
`ifdef AES_SPI_READBACK_EN
                    state_d = TURN;
                    mode_d  = 1'b1;
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    simo_d = key_q[cnt_q + 8'd1];
                end
            end
`ifdef AES_SPI_READBACK_EN
            TURN: begin
                state_d = READ;
                cnt_d   = 8'd0;
                css_d   = 1'b0;
            end
            // SOMI bit k lands on the (k+2)-th edge after CSS falls, so nothing is sampled at cnt 0.
            READ: begin
                shift_en = (cnt_q != 8'd0);
                if (cnt_q == 8'd127) begin
                    state_d = CAPT;
                    css_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CAPT: begin
                capture = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                css_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            SIMO    <= 1'b0;
            CSS     <= 1'b1;
            mode    <= 1'b0;
            size    <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            msg_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            SIMO    <= simo_d;
            CSS     <= css_d;
            mode    <= mode_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            if (latch) begin
                msg_q <= msg_in;
                size  <= size_in;
                // Right-align the key so the first transmitted bit is always key_q[0].
                case (size_in)
                    2'b00:   key_q <= key_in >> 128;
                    2'b01:   key_q <= key_in >> 64;
                    default: key_q <= key_in;
                endcase
            end
        end
    end

`ifdef AES_SPI_READBACK_EN
    logic [127:0] rx_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sr  <= '0;
            result <= '0;
        end else begin
            if (shift_en) rx_sr <= {SOMI, rx_sr[127:1]};
            if (capture)  result <= {SOMI, rx_sr[127:1]};
        end
    end
`else
    logic unused_readback;
    assign unused_readback = SOMI ^ shift_en ^ capture;
    assign result = '0;
`endif

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: randomized frames against a bit-stream model built from the frame rules.
module tb_aes_spi_master;

    localparam int PAD = 1;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   size_in;
    logic [127:0] msg_in;
    logic [255:0] key_in;
    logic         SOMI;
    logic         SIMO, CSS, mode, busy, done, err;
    logic [1:0]   size;
    logic [127:0] result;
    logic [2:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    logic [0:0]   exp_q[$];
    logic [0:0]   got_q[$];
    logic [127:0] rb_word = '0;
    logic [127:0] last_result = '0;
    int           rk;

    aes_spi_master #(.PAD_BITS(PAD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .size_in(size_in),
        .msg_in(msg_in), .key_in(key_in), .SOMI(SOMI),
        .SIMO(SIMO), .CSS(CSS), .mode(mode), .size(size), .busy(busy),
        .done(done), .err(err), .result(result), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Slave: sees CSS low in decrypt mode and launches readback bit k on the edge after it saw bit k-1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            SOMI <= 1'b0;
            rk   <= 0;
        end else if (CSS == 1'b0 && mode == 1'b1) begin
            SOMI <= rb_word[rk];
            rk   <= rk + 1;
        end else begin
            SOMI <= 1'b0;
            rk   <= 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_txn(input string tag, input logic [127:0] m, input logic [255:0] k,
                           input logic [1:0] sz, input logic [127:0] rbw, input bit poke);
        int n, l, exp_done, first_high, done_j, done_cnt, busy_bad, read_len, bit_bad;
        logic [127:0] got_msg;
        logic [255:0] got_key, key_mask;
        n = (sz == 2'b00) ? 128 : (sz == 2'b01) ? 192 : 256;
        l = PAD + 128 + GAP + n;
`ifdef AES_SPI_READBACK_EN
        exp_done = l + 130;
`else
        exp_done = l;
`endif
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < PAD; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 128; i++) exp_q.push_back(m[i]);
        for (int i = 0; i < GAP; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) exp_q.push_back(k[256-n+i]);
        rb_word    = rbw;
        first_high = -1;
        done_j     = -1;
        done_cnt   = 0;
        busy_bad   = 0;
        read_len   = 0;
        @(negedge clk);
        msg_in  = m;
        key_in  = k;
        size_in = sz;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= exp_done + 3; j++) begin
            if (j > 0) @(negedge clk);
            if (CSS == 1'b0 && mode == 1'b0) got_q.push_back(SIMO);
            if (CSS == 1'b0 && mode == 1'b1) read_len++;
            if (CSS == 1'b1 && first_high < 0) first_high = j;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
            end
            if ((j < exp_done) ? (busy !== 1'b1) : (busy !== 1'b0)) busy_bad++;
            if (poke && j == 40) begin
                start  = 1'b1;
                msg_in = ~m;
            end else begin
                start = 1'b0;
            end
        end
        bit_bad = 0;
        got_msg = '0;
        got_key = '0;
        key_mask = '0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bit_bad++;
        if (got_q.size() >= PAD + 128 + GAP + n) begin
            for (int i = 0; i < 128; i++) got_msg[i] = got_q[PAD+i];
            for (int i = 0; i < n; i++) begin
                got_key[256-n+i]  = got_q[PAD+128+GAP+i];
                key_mask[256-n+i] = 1'b1;
            end
        end
        check({tag, "_css_low_len"}, first_high, l);
        check({tag, "_stream_len"}, got_q.size(), exp_q.size());
        check({tag, "_stream_bits"}, bit_bad, 0);
        check({tag, "_slave_msg"}, got_msg, m);
        check({tag, "_slave_key"}, got_key, k & key_mask);
        check({tag, "_done_time"}, done_j, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_size"}, size, sz);
`ifdef AES_SPI_READBACK_EN
        check({tag, "_read_len"}, read_len, 128);
        check({tag, "_result"}, result, rbw);
`else
        check({tag, "_read_len"}, read_len, 0);
        check({tag, "_result"}, result, 128'd0);
`endif
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        size_in = 2'b00;
        msg_in  = '0;
        key_in  = '0;

        repeat (3) @(negedge clk);
        check("rst_css", CSS, 1'b1);
        check("rst_simo", SIMO, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 128'd0);
        check("rst_mode_size", {mode, size}, 3'b000);
        reset = 1'b1;
        @(negedge clk);
        check("idle_css", CSS, 1'b1);

        run_txn("size00", 128'h0123456789ABCDEF_FEDCBA9876543210,
                {128'h000102030405060708090A0B0C0D0E0F, rand128()}, 2'b00,
                128'hDEADBEEF_00112233_44556677_8899AABB, 1'b0);
        last_result = result;

        run_txn("size01", rand128(), {rand128(), rand128()}, 2'b01, rand128(), 1'b0);
        run_txn("size10_poke", rand128(), {rand128(), rand128()}, 2'b10, rand128(), 1'b1);

        // Illegal size: err pulses once and the link stays idle.
        @(negedge clk);
        size_in = 2'b11;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ill_err", err, 1'b1);
        check("ill_css", CSS, 1'b1);
        check("ill_busy", busy, 1'b0);
        @(negedge clk);
        check("ill_err_clear", err, 1'b0);
        check("ill_css_hold", CSS, 1'b1);

        // Reset in the middle of the message.
        msg_in  = rand128();
        key_in  = {rand128(), rand128()};
        size_in = 2'($urandom_range(0, 2));
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_css_before", CSS, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_css", CSS, 1'b1);
        check("mid_busy", busy, 1'b0);
        check("mid_result", result, 128'd0);
        check("mid_done_err", {done, err}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_idle", {CSS, busy}, 2'b10);

        run_txn("after_rst", rand128(), {rand128(), rand128()}, 2'($urandom_range(0, 2)),
                rand128(), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
